// File: rtl/add8_err_profiler.sv
// Exhaustive error profiler for 8-bit approximate adders: sweeps all operand
// pairs, compares the adder result to the exact sum and accumulates error metrics.
module add8_err_profiler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  a_o,
    output logic [7:0]  b_o,
    input  logic [8:0]  dut_o_i,
    output logic        busy,
    output logic        done,
    output logic [24:0] sum_abs_err,
    output logic [34:0] sum_sq_err,
    output logic [16:0] err_count,
    output logic [8:0]  wce,
    output logic [19:0] hd_total
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic   drain_q;
    logic   last_pair;
    logic   accept;

    logic [8:0]  exact_p0;
    logic [8:0]  e_p1;
    logic [3:0]  h_p1;
    logic        vld_p1;
    logic [17:0] sq_p1;

    function automatic logic [8:0] abs_err(input logic [8:0] o, input logic [8:0] x);
        logic signed [9:0] d;
        d = signed'({1'b0, o}) - signed'({1'b0, x});
        return (d < 0) ? 9'(-d) : 9'(d);
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    function automatic logic [17:0] square9(input logic [8:0] v);
        return 18'(v) * 18'(v);
    endfunction

    assign last_pair = (a_o == 8'hFF) && (b_o == 8'hFF);
    assign accept    = (state_q == IDLE) && start;
    assign busy      = (state_q == SWEEP) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (last_pair) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
        end
    end

    // Operand generator: a_o runs fastest and both counters wrap to 0 after (255,255)
    always_ff @(posedge clk) begin
        if (rst) begin
            a_o <= 8'd0;
            b_o <= 8'd0;
        end else if (state_q == SWEEP) begin
            a_o <= a_o + 8'd1;
            if (a_o == 8'hFF) b_o <= b_o + 8'd1;
        end
    end

    // Stage 0 -> 1: capture error magnitude and Hamming distance (only in SWEEP, so X never enters)
    assign exact_p0 = {1'b0, a_o} + {1'b0, b_o};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            e_p1   <= 9'd0;
            h_p1   <= 4'd0;
        end else begin
            vld_p1 <= (state_q == SWEEP);
            if (state_q == SWEEP) begin
                e_p1 <= abs_err(dut_o_i, exact_p0);
                h_p1 <= popcount9(dut_o_i ^ exact_p0);
            end
        end
    end

    // Stage 1 -> 2: accumulate metrics; cleared only when a new sweep is accepted
    assign sq_p1 = square9(e_p1);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            sum_abs_err <= 25'd0;
            sum_sq_err  <= 35'd0;
            err_count   <= 17'd0;
            wce         <= 9'd0;
            hd_total    <= 20'd0;
        end else if (vld_p1) begin
            sum_abs_err <= sum_abs_err + {16'd0, e_p1};
            sum_sq_err  <= sum_sq_err + {17'd0, sq_p1};
            err_count   <= err_count + {16'd0, (e_p1 != 9'd0)};
            if (e_p1 > wce) wce <= e_p1;
            hd_total    <= hd_total + {16'd0, h_p1};
        end
    end

endmodule

// File: tb/tb_add8_err_profiler.sv
// Bench for add8_err_profiler: a mixed-behaviour approximate adder model is
// swept once end to end; expected metrics are queued at start and popped at done.
module tb_add8_err_profiler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a_o;
    logic [7:0]  b_o;
    logic [8:0]  dut_o_i;
    logic        busy;
    logic        done;
    logic [24:0] sum_abs_err;
    logic [34:0] sum_sq_err;
    logic [16:0] err_count;
    logic [8:0]  wce;
    logic [19:0] hd_total;

    typedef struct {
        longint sae;
        longint sse;
        longint cnt;
        longint wce;
        longint hd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    add8_err_profiler dut (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a_o), .b_o(b_o), .dut_o_i(dut_o_i),
        .busy(busy), .done(done),
        .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err),
        .err_count(err_count), .wce(wce), .hd_total(hd_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Approximate adder under test: behaviour chosen by the low bits of A
    function automatic logic [8:0] adder_model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        x = {1'b0, a} + {1'b0, b};
        case (a[1:0])
            2'd0:    return x;
            2'd1:    return x & 9'h1FE;
            2'd2:    return 9'd0;
            default: return x ^ 9'h100;
        endcase
    endfunction

    always_comb dut_o_i = adder_model(a_o, b_o);

    function automatic exp_t ref_metrics(input int n);
        exp_t r;
        r.sae = 0; r.sse = 0; r.cnt = 0; r.wce = 0; r.hd = 0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a, b;
            logic [8:0] o, x;
            longint e;
            a = 8'(i % 256);
            b = 8'(i / 256);
            o = adder_model(a, b);
            x = 9'(i % 256 + i / 256);
            e = longint'(o) - longint'(x);
            if (e < 0) e = -e;
            r.sae += e;
            r.sse += e * e;
            if (e != 0) r.cnt++;
            if (e > r.wce) r.wce = e;
            r.hd += $countones(o ^ x);
        end
        return r;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_zero_state(input string pfx);
        check({pfx, "_a"}, a_o, 0);
        check({pfx, "_b"}, b_o, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_sae"}, sum_abs_err, 0);
        check({pfx, "_sse"}, sum_sq_err, 0);
        check({pfx, "_cnt"}, err_count, 0);
        check({pfx, "_wce"}, wce, 0);
        check({pfx, "_hd"}, hd_total, 0);
    endtask

    task automatic check_metrics(input string pfx, input exp_t e);
        check({pfx, "_sae"}, sum_abs_err, e.sae);
        check({pfx, "_sse"}, sum_sq_err, e.sse);
        check({pfx, "_cnt"}, err_count, e.cnt);
        check({pfx, "_wce"}, wce, e.wce);
        check({pfx, "_hd"}, hd_total, e.hd);
    endtask

    initial begin
        exp_t full, part, got_exp;
        int order_errs, busy_cnt, done_cnt;

        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Sweep aborted by reset in cycle T+1000
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 1000; k++) begin
            @(posedge clk); #1;
        end
        part = ref_metrics(998);
        check("partial_busy", busy, 1);
        check("partial_sae", sum_abs_err, part.sae);
        check("partial_hd", hd_total, part.hd);
        check("partial_a", a_o, 999 % 256);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_state("abort");

        // Full sweep with stray start pulses at T+5 and during DONE
        full = ref_metrics(65536);
        sb.push_back(full);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        order_errs = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 65545; k++) begin
            if (busy) busy_cnt++;
            if (k <= 65536) begin
                if (a_o != 8'((k - 1) % 256) || b_o != 8'((k - 1) / 256)) order_errs++;
            end
            if (k == 1)     begin check("pair0_a", a_o, 0);     check("pair0_b", b_o, 0); end
            if (k == 2)     begin check("pair1_a", a_o, 1);     check("pair1_b", b_o, 0); end
            if (k == 256)   begin check("pair255_a", a_o, 255); check("pair255_b", b_o, 0); end
            if (k == 257)   begin check("pair256_a", a_o, 0);   check("pair256_b", b_o, 1); end
            if (k == 65536) begin check("last_a", a_o, 255);    check("last_b", b_o, 255); end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("done_cycle", k, 65539);
                    if (sb.size() > 0) begin
                        got_exp = sb.pop_front();
                        check_metrics("sweep", got_exp);
                    end else begin
                        check("sb_underflow", 0, 1);
                    end
                end
            end
            start = (k == 5) || done;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_count", done_cnt, 1);
        check("busy_cycles", busy_cnt, 65538);
        check("pattern_order", order_errs, 0);
        check("sb_left", sb.size(), 0);
        check("idle_busy", busy, 0);
        check_metrics("hold", full);

        // A new start clears the held results on acceptance
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_a", a_o, 0);
        check("restart_sae", sum_abs_err, 0);
        check("restart_sse", sum_sq_err, 0);
        check("restart_cnt", err_count, 0);
        check("restart_wce", wce, 0);
        check("restart_hd", hd_total, 0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
